// File: rtl/sdp_ram_pipe_pkg.sv
// Shared definitions for the byte-lane simple dual-port RAM.
//   RDW_READ_FIRST / RDW_WRITE_FIRST : same-address read-during-write modes
//   calc_lanes()                     : number of 8-bit lanes in a data word
package sdp_ram_pipe_pkg;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;

   function automatic int calc_lanes(input int data_len);
      return data_len / 8;
   endfunction

endpackage

// File: rtl/sdp_ram_lane.sv
// One 8-bit lane: simple dual-port array, one write port, one read port
// with a registered (1-cycle) output. The read is naturally read-first:
// a write and a read to the same word on one edge returns the old byte.
//   clk, rst           : clock, synchronous reset (clears the output register only)
//   wr_en/addr/data    : byte write, already qualified by reset and byte enable
//   rd_en/addr         : read issue, already qualified by reset
//   rd_data            : registered read byte, holds between reads
module sdp_ram_lane #(
   parameter int ADDR_LEN = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [ADDR_LEN-1:0] wr_addr,
   input  logic [7:0]          wr_data,
   input  logic                rd_en,
   input  logic [ADDR_LEN-1:0] rd_addr,
   output logic [7:0]          rd_data
);

   // Power-up contents are zero; reset never touches the array.
   logic [7:0] mem [2**ADDR_LEN] = '{default: 8'h00};

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= 8'h00;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/sdp_ram_pipe.sv
// Byte-lane simple dual-port RAM with selectable read latency (1 or 2) and
// selectable same-address read-during-write behaviour.
//   clk, rst            : clock, synchronous active-high reset
//   wr_req/addr/data/be : write strobe, address, word, byte-lane enables
//   rd_req/addr         : read strobe and address
//   rd_data, rd_valid   : read word (holds between results) and 1-cycle result pulse
// Strobe semantics: there is no back-pressure. A strobe high on an edge with
// rst low is accepted on that edge; every accepted read produces exactly one
// rd_valid pulse RD_LATENCY cycles later unless a reset intervenes.
module sdp_ram_pipe
   import sdp_ram_pipe_pkg::*;
#(
   parameter int  ADDR_LEN   = 12,
   parameter int  DATA_LEN   = 32,
   parameter int  RD_LATENCY = 1,
   parameter int  RDW_MODE   = RDW_READ_FIRST,
   localparam int LANES      = calc_lanes(DATA_LEN)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_req,
   input  logic [ADDR_LEN-1:0] wr_addr,
   input  logic [DATA_LEN-1:0] wr_data,
   input  logic [LANES-1:0]    wr_be,
   input  logic                rd_req,
   input  logic [ADDR_LEN-1:0] rd_addr,
   output logic [DATA_LEN-1:0] rd_data,
   output logic                rd_valid
);

   generate
      if ((DATA_LEN % 8) != 0 || DATA_LEN < 8) begin : g_bad_data_len
         $error("sdp_ram_pipe: DATA_LEN must be a positive multiple of 8");
      end
      if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
         $error("sdp_ram_pipe: RD_LATENCY must be 1 or 2");
      end
   endgenerate

   logic                wr_fire;
   logic                rd_fire;
   logic                same_addr;
   logic [DATA_LEN-1:0] lane_q;      // registered array output, all lanes
   logic [DATA_LEN-1:0] byp_data_q;  // write word captured at the read issue edge
   logic [LANES-1:0]    byp_sel_q;   // lanes to take from byp_data_q
   logic                s1_valid;
   logic [DATA_LEN-1:0] s1_data;

   assign wr_fire   = wr_req & ~rst;
   assign rd_fire   = rd_req & ~rst;
   assign same_addr = wr_req & rd_req & (wr_addr == rd_addr);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sdp_ram_lane #(.ADDR_LEN(ADDR_LEN)) u_lane (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (wr_fire & wr_be[i]),
         .wr_addr (wr_addr),
         .wr_data (wr_data[8*i +: 8]),
         .rd_en   (rd_fire),
         .rd_addr (rd_addr),
         .rd_data (lane_q[8*i +: 8])
      );
   end

   // The arrays are read-first. Write-first is obtained by remembering, at
   // the issue edge, which lanes were being written to the same word and
   // substituting the written bytes. Bypass state only changes on a read,
   // so the merged word holds between reads just like the lane registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         byp_sel_q <= '0;
      end else begin
         s1_valid <= rd_req;
         if (rd_req) begin
            byp_sel_q  <= (RDW_MODE == RDW_WRITE_FIRST && same_addr) ? wr_be : '0;
            byp_data_q <= wr_data;
         end
      end
   end

   always_comb begin
      s1_data = lane_q;
      for (int i = 0; i < LANES; i++) begin
         if (byp_sel_q[i]) begin
            s1_data[8*i +: 8] = byp_data_q[8*i +: 8];
         end
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic [DATA_LEN-1:0] s2_data;
         logic                s2_valid;

         // Fully pipelined: a new word enters every cycle s1_valid is high.
         always_ff @(posedge clk) begin
            if (rst) begin
               s2_valid <= 1'b0;
               s2_data  <= '0;
            end else begin
               s2_valid <= s1_valid;
               if (s1_valid) begin
                  s2_data <= s1_data;
               end
            end
         end

         assign rd_data  = s2_data;
         assign rd_valid = s2_valid;
      end else begin : g_lat1
         assign rd_data  = s1_data;
         assign rd_valid = s1_valid;
      end
   endgenerate

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// Four DUT copies share one stimulus stream: {LAT1,LAT2} x {read-first,
// write-first}. A word-level reference memory predicts each read result and
// the cycle it must appear; every cycle each copy's rd_valid and rd_data are
// compared with the prediction.
module tb_sdp_ram_pipe;

   localparam int AL = 12;
   localparam int DL = 32;
   localparam int NI = 4;

   // clock / reset block
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          wr_req;
   logic [AL-1:0] wr_addr;
   logic [DL-1:0] wr_data;
   logic [3:0]    wr_be;
   logic          rd_req;
   logic [AL-1:0] rd_addr;
   logic [DL-1:0] rdat [NI];
   logic          rval [NI];

   sdp_ram_pipe #(.ADDR_LEN(AL), .DATA_LEN(DL), .RD_LATENCY(1), .RDW_MODE(0)) u_l1_rf (
      .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rdat[0]), .rd_valid(rval[0]));
   sdp_ram_pipe #(.ADDR_LEN(AL), .DATA_LEN(DL), .RD_LATENCY(1), .RDW_MODE(1)) u_l1_wf (
      .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rdat[1]), .rd_valid(rval[1]));
   sdp_ram_pipe #(.ADDR_LEN(AL), .DATA_LEN(DL), .RD_LATENCY(2), .RDW_MODE(0)) u_l2_rf (
      .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rdat[2]), .rd_valid(rval[2]));
   sdp_ram_pipe #(.ADDR_LEN(AL), .DATA_LEN(DL), .RD_LATENCY(2), .RDW_MODE(1)) u_l2_wf (
      .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rdat[3]), .rd_valid(rval[3]));

   // reference model and scoreboard
   typedef struct {
      int            inst;
      int            due;
      logic [DL-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   logic [DL-1:0] ref_mem [2**AL];
   logic [DL-1:0] held [NI];
   int            cyc;
   int            compared;
   int            mismatched;

   function automatic int lat_of(input int i);
      return (i >= 2) ? 2 : 1;
   endfunction

   function automatic bit write_first(input int i);
      return (i % 2) == 1;
   endfunction

   task automatic check(input string tag, input logic [DL-1:0] obs, input logic [DL-1:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
      end
   endtask

   // Applies the current inputs to the model as of the coming edge.
   task automatic model_edge();
      logic [DL-1:0] old_w;
      logic [DL-1:0] new_w;
      if (rst) begin
         for (int j = exp_q.size() - 1; j >= 0; j--) begin
            if (exp_q[j].due >= cyc) exp_q.delete(j);
         end
      end else begin
         if (rd_req) begin
            old_w = ref_mem[rd_addr];
            new_w = old_w;
            if (wr_req && wr_addr == rd_addr) begin
               for (int b = 0; b < 4; b++) begin
                  if (wr_be[b]) new_w[8*b +: 8] = wr_data[8*b +: 8];
               end
            end
            for (int i = 0; i < NI; i++) begin
               exp_t e;
               e.inst = i;
               e.due  = cyc + lat_of(i) - 1;
               e.data = write_first(i) ? new_w : old_w;
               exp_q.push_back(e);
            end
         end
         if (wr_req) begin
            for (int b = 0; b < 4; b++) begin
               if (wr_be[b]) ref_mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
            end
         end
      end
   endtask

   task automatic check_outputs();
      logic exp_v;
      for (int i = 0; i < NI; i++) begin
         exp_v = 1'b0;
         for (int j = 0; j < exp_q.size(); j++) begin
            if (exp_q[j].inst == i && exp_q[j].due == cyc) begin
               exp_v   = 1'b1;
               held[i] = exp_q[j].data;
               exp_q.delete(j);
               break;
            end
         end
         if (rst) held[i] = '0;
         check($sformatf("valid%0d", i), {31'd0, rval[i]}, {31'd0, exp_v});
         check($sformatf("data%0d", i), rdat[i], held[i]);
      end
   endtask

   // driver tasks
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
      cyc++;
   endtask

   task automatic idle();
      rst    = 1'b0;
      wr_req = 1'b0;
      rd_req = 1'b0;
      wr_be  = 4'h0;
   endtask

   task automatic set_wr(input logic [AL-1:0] a, input logic [DL-1:0] d, input logic [3:0] be);
      wr_req  = 1'b1;
      wr_addr = a;
      wr_data = d;
      wr_be   = be;
   endtask

   task automatic set_rd(input logic [AL-1:0] a);
      rd_req  = 1'b1;
      rd_addr = a;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      cyc        = 0;
      for (int a = 0; a < 2**AL; a++) ref_mem[a] = '0;
      for (int i = 0; i < NI; i++) held[i] = '0;
      idle();
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;

      // reset: outputs zero, no valid
      rst = 1'b1;
      repeat (3) tick();
      idle();
      tick();

      // full write then read, latency 1
      set_wr(12'h010, 32'hA1B2C3D4, 4'hF); tick(); idle();
      set_rd(12'h010); tick(); idle();
      check("full_wr_l1_data", rdat[0], 32'hA1B2C3D4);
      check("full_wr_l1_valid", {31'd0, rval[0]}, 32'd1);
      tick();

      // partial write, lanes 0 and 2
      set_wr(12'h010, 32'h11223344, 4'b0101); tick(); idle();
      set_rd(12'h010); tick(); idle();
      check("partial_wr", rdat[0], 32'hA122C344);
      tick();

      // same-address collision in both modes
      set_wr(12'h020, 32'h00000000, 4'hF); tick(); idle();
      set_wr(12'h020, 32'hFFFFFFFF, 4'b0011); set_rd(12'h020); tick(); idle();
      check("coll_read_first", rdat[0], 32'h00000000);
      check("coll_write_first", rdat[1], 32'h0000FFFF);
      tick();

      // write right after a read must not disturb the in-flight LAT2 result
      set_wr(12'h021, 32'hCAFEF00D, 4'hF); tick(); idle();
      set_rd(12'h021); tick(); idle();
      set_wr(12'h021, 32'h0BADBEEF, 4'hF); tick(); idle();
      check("wr_after_rd_l2", rdat[2], 32'hCAFEF00D);
      tick();

      // eight back-to-back reads at latency 2
      for (int a = 0; a < 8; a++) begin
         set_wr(12'(a), 32'h100 + 32'(a), 4'hF); tick(); idle();
      end
      for (int a = 0; a < 8; a++) begin
         set_rd(12'(a)); tick();
      end
      idle();
      repeat (3) tick();

      // reset one cycle after a read issue discards it; memory survives
      set_wr(12'h030, 32'h12345678, 4'hF); tick(); idle();
      set_rd(12'h030); tick(); idle();
      rst = 1'b1; tick();
      check("rst_discard_valid", {31'd0, rval[2]}, 32'd0);
      check("rst_discard_data", rdat[2], 32'd0);
      idle(); repeat (3) tick();
      set_rd(12'h030); tick(); idle(); tick();
      check("mem_kept_after_rst", rdat[2], 32'h12345678);

      // idle hold with unrelated writes
      set_wr(12'h040, 32'h5A5A5A5A, 4'hF); tick(); idle();
      set_rd(12'h040); tick(); idle(); tick();
      for (int n = 0; n < 10; n++) begin
         set_wr(12'h050 + 12'(n), $urandom, 4'(($urandom_range(0, 15)))); tick(); idle();
      end
      check("idle_hold_l1", rdat[0], 32'h5A5A5A5A);
      check("idle_hold_l2", rdat[3], 32'h5A5A5A5A);

      // randomized traffic over a small window to force collisions
      for (int n = 0; n < 800; n++) begin
         rst     = ($urandom_range(0, 39) == 0);
         wr_req  = $urandom_range(0, 1);
         wr_addr = 12'($urandom_range(0, 15));
         wr_data = $urandom;
         wr_be   = 4'($urandom_range(0, 15));
         rd_req  = $urandom_range(0, 2) != 0;
         rd_addr = 12'($urandom_range(0, 15));
         tick();
      end
      idle();
      repeat (4) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
